// File: rtl/setting_reg_block.sv
// Addressed setting register: captures in[width-1:0] on a strobed write to my_addr
// and emits a registered one-cycle changed pulse for the accepted write.
module setting_reg_block #(
    parameter [6:0]        my_addr         = 7'd0,
    parameter int unsigned width           = 32,
    parameter [31:0]       at_reset        = 32'd0,
    parameter bit          changed_on_diff = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic [6:0]       addr,
    input  logic [31:0]      in,
    output logic [width-1:0] out,
    output logic             changed
);

    localparam logic [width-1:0] RESET_VAL = at_reset[width-1:0];

    logic             wr_hit;
    logic [width-1:0] out_d,     out_q;
    logic             changed_d, changed_q;

    always_comb begin
        wr_hit    = strobe && (addr == my_addr);
        out_d     = out_q;
        changed_d = 1'b0;
        if (wr_hit) begin
            out_d     = in[width-1:0];
            changed_d = changed_on_diff ? (in[width-1:0] != out_q) : 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q     <= RESET_VAL;
            changed_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            changed_q <= changed_d;
        end
    end

    assign out     = out_q;
    assign changed = changed_q;

    // Upper write-data bits are intentionally discarded for narrow settings.
    if (width < 32) begin : g_unused
        logic unused_in_hi;
        assign unused_in_hi = ^in[31:width];
    end

endmodule

// File: tb/tb_setting_reg_block.sv
// Self-checking bench: three setting_reg_block configurations share one stimulus
// stream and are compared against a per-instance behavioural model.
module tb_setting_reg_block;

    localparam int N = 3;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        strobe = 1'b0;
    logic [6:0]  addr   = '0;
    logic [31:0] din    = '0;

    logic [15:0] o0, o1;
    logic [2:0]  o2;
    logic        c0, c1, c2;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Per-instance configuration as seen by the model.
    int unsigned p_addr [N] = '{5, 5, 127};
    int unsigned p_width[N] = '{16, 16, 3};
    logic [31:0] p_rst  [N] = '{32'h0000_1234, 32'h0000_0055, 32'h0000_000A};
    bit          p_diff [N] = '{1'b0, 1'b1, 1'b0};

    logic [31:0] m_out[N];
    logic        m_chg[N];

    setting_reg_block #(.my_addr(7'd5), .width(16), .at_reset(32'h1234), .changed_on_diff(1'b0)) dut0 (
        .clock(clk), .reset(rst_n), .strobe(strobe), .addr(addr), .in(din), .out(o0), .changed(c0));

    setting_reg_block #(.my_addr(7'd5), .width(16), .at_reset(32'h0055), .changed_on_diff(1'b1)) dut1 (
        .clock(clk), .reset(rst_n), .strobe(strobe), .addr(addr), .in(din), .out(o1), .changed(c1));

    setting_reg_block #(.my_addr(7'd127), .width(3), .at_reset(32'h000A), .changed_on_diff(1'b0)) dut2 (
        .clock(clk), .reset(rst_n), .strobe(strobe), .addr(addr), .in(din), .out(o2), .changed(c2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mask(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_out[i] = p_rst[i] & mask(p_width[i]);
            m_chg[i] = 1'b0;
        end
    endtask

    // Model of one rising edge, using the inputs currently applied.
    task automatic model_edge();
        logic [31:0] nv;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (strobe && (int'(addr) == p_addr[i])) begin
                nv       = din & mask(p_width[i]);
                m_chg[i] = p_diff[i] ? (nv != m_out[i]) : 1'b1;
                m_out[i] = nv;
            end else begin
                m_chg[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_out0"}, {16'h0, o0}, m_out[0]);
        check({tag, "_chg0"}, {31'h0, c0}, {31'h0, m_chg[0]});
        check({tag, "_out1"}, {16'h0, o1}, m_out[1]);
        check({tag, "_chg1"}, {31'h0, c1}, {31'h0, m_chg[1]});
        check({tag, "_out2"}, {29'h0, o2}, m_out[2]);
        check({tag, "_chg2"}, {31'h0, c2}, {31'h0, m_chg[2]});
    endtask

    task automatic step(input string tag, input logic s, input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        strobe = s;
        addr   = a;
        din    = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: write, then async reset mid-cycle, then idle.
        step("wr_beef", 1'b1, 7'd5, 32'hDEAD_BEEF);
        step("after_beef", 1'b0, 7'd5, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        model_edge();
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step("idle", 1'b0, 7'd0, 32'h0);

        step("wr_beef2", 1'b1, 7'd5, 32'hDEAD_BEEF);
        step("beef_hold", 1'b0, 7'd5, 32'hDEAD_BEEF);
        step("wrong_addr", 1'b1, 7'd6, 32'h0000_00AA);
        step("no_strobe", 1'b0, 7'd5, 32'h0000_00AA);
        step("b2b_1", 1'b1, 7'd5, 32'd1);
        step("b2b_2", 1'b1, 7'd5, 32'd2);
        step("b2b_3", 1'b1, 7'd5, 32'd3);
        step("same_7a", 1'b1, 7'd5, 32'd7);
        step("same_7b", 1'b1, 7'd5, 32'd7);
        step("diff_8", 1'b1, 7'd5, 32'd8);
        step("addr127", 1'b1, 7'd127, 32'hFFFF_FFFD);
        step("addr127_hold", 1'b0, 7'd127, 32'h0);

        // Reset asserted across a strobed write: the write must be lost.
        @(negedge clk);
        strobe = 1'b1;
        addr   = 7'd127;
        din    = 32'hFFFF_FFFF;
        rst_n  = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        check_all("rst_vs_wr");

        // First edge after release must accept a write.
        @(negedge clk);
        rst_n  = 1'b1;
        strobe = 1'b1;
        addr   = 7'd5;
        din    = 32'h0000_4321;
        @(posedge clk);
        model_edge();
        #1;
        check_all("first_after_rst");

        for (int k = 0; k < 400; k++) begin
            logic        s;
            logic [6:0]  a;
            logic [31:0] d;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = 7'd5;
                1: a = 7'd127;
                2: a = 7'd6;
                default: a = 7'($urandom);
            endcase
            d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            step("rand", s, a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
